// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - two-requester round-robin front end for a shared 2-stage multiplier
//
// Purpose:
//   Two requesters share one pipelined multiplier. A 1-bit last-grant
//   pointer gives round-robin arbitration on ties. Stage 1 captures the
//   winning operands, requester id and signed flag. Stage 2 registers the
//   exact 2*n-bit product and presents it downstream with a valid/ready
//   handshake. Results leave in acceptance order.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_vld / req0_rdy       requester 0 handshake
//   req0_a, req0_b            requester 0 operands (n bits each)
//   req0_signed               requester 0 mode (1 = signed, 0 = unsigned)
//   req1_*                    same set of ports for requester 1
//   res_vld / res_rdy         result handshake
//   res                       2*n-bit product
//   res_id                    requester that issued the result
//   res_signed                mode of the issued operation

module mul_arbiter #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           req0_vld,
  output logic           req0_rdy,
  input  logic [n-1:0]   req0_a,
  input  logic [n-1:0]   req0_b,
  input  logic           req0_signed,

  input  logic           req1_vld,
  output logic           req1_rdy,
  input  logic [n-1:0]   req1_a,
  input  logic [n-1:0]   req1_b,
  input  logic           req1_signed,

  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*n-1:0] res,
  output logic           res_id,
  output logic           res_signed
);

  // Stage 1: captured operation
  logic         s1_vld;
  logic [n-1:0] s1_a;
  logic [n-1:0] s1_b;
  logic         s1_id;
  logic         s1_signed;

  // 1 = requester 1 was granted last, so requester 0 wins the next tie
  logic         last_grant;

  logic         s2_load;
  logic         s1_open;
  logic         grant0;
  logic         grant1;
  logic         accept;

  logic [n-1:0] sel_a;
  logic [n-1:0] sel_b;
  logic         sel_signed;
  logic         sel_id;

  logic [2*n-1:0] ext_a;
  logic [2*n-1:0] ext_b;
  logic [2*n-1:0] product;

  // Pipeline flow control and arbitration
  always_comb begin
    s2_load  = 1'b0;
    s1_open  = 1'b0;
    grant0   = 1'b0;
    grant1   = 1'b0;
    req0_rdy = 1'b0;
    req1_rdy = 1'b0;
    accept   = 1'b0;

    // Stage 2 takes new data when empty or when its result is being consumed
    s2_load = !res_vld || res_rdy;
    // Stage 1 can take a new op when empty or when it moves into stage 2 now
    s1_open = !s1_vld || s2_load;

    grant0 = req0_vld && (!req1_vld || last_grant);
    grant1 = req1_vld && (!req0_vld || !last_grant);

    req0_rdy = grant0 && s1_open;
    req1_rdy = grant1 && s1_open;
    accept   = req0_rdy || req1_rdy;
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_a      = req0_a;
    sel_b      = req0_b;
    sel_signed = req0_signed;
    sel_id     = 1'b0;
    if (grant1) begin
      sel_a      = req1_a;
      sel_b      = req1_b;
      sel_signed = req1_signed;
      sel_id     = 1'b1;
    end
  end

  // Extending both operands to 2*n bits and keeping the low 2*n bits of the
  // product gives the exact two's-complement result in signed mode and the
  // exact unsigned result otherwise; one multiplier serves both modes.
  always_comb begin
    ext_a   = '0;
    ext_b   = '0;
    product = '0;
    if (s1_signed) begin
      ext_a = {{n{s1_a[n-1]}}, s1_a};
      ext_b = {{n{s1_b[n-1]}}, s1_b};
    end else begin
      ext_a = {{n{1'b0}}, s1_a};
      ext_b = {{n{1'b0}}, s1_b};
    end
    product = ext_a * ext_b;
  end

  // Stage 1 register and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= 1'b0;
      s1_signed  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        s1_vld     <= 1'b1;
        s1_a       <= sel_a;
        s1_b       <= sel_b;
        s1_id      <= sel_id;
        s1_signed  <= sel_signed;
        last_grant <= sel_id;
      end else if (s2_load) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // Stage 2 register drives the result ports directly
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld    <= 1'b0;
      res        <= '0;
      res_id     <= 1'b0;
      res_signed <= 1'b0;
    end else if (s2_load) begin
      res_vld <= s1_vld;
      // Payload only changes for a real operation so idle outputs stay quiet
      if (s1_vld) begin
        res        <= product;
        res_id     <= s1_id;
        res_signed <= s1_signed;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter with a result scoreboard

module tb_mul_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_vld = 1'b0;
  logic           req0_rdy;
  logic [N-1:0]   req0_a = '0;
  logic [N-1:0]   req0_b = '0;
  logic           req0_signed = 1'b0;
  logic           req1_vld = 1'b0;
  logic           req1_rdy;
  logic [N-1:0]   req1_a = '0;
  logic [N-1:0]   req1_b = '0;
  logic           req1_signed = 1'b0;
  logic           res_vld;
  logic           res_rdy = 1'b1;
  logic [2*N-1:0] res;
  logic           res_id;
  logic           res_signed;

  int checks = 0;
  int errors = 0;

  // Expected results: {product, id, signed}
  logic [2*N+1:0] sb[$];

  mul_arbiter #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_vld    (req0_vld),
    .req0_rdy    (req0_rdy),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_signed (req0_signed),
    .req1_vld    (req1_vld),
    .req1_rdy    (req1_rdy),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_signed (req1_signed),
    .res_vld     (res_vld),
    .res_rdy     (res_rdy),
    .res         (res),
    .res_id      (res_id),
    .res_signed  (res_signed)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] ref_mul(logic [N-1:0] a, logic [N-1:0] b, logic s);
    int ia;
    int ib;
    int p;
    ia = s ? {{(32-N){a[N-1]}}, a} : {{(32-N){1'b0}}, a};
    ib = s ? {{(32-N){b[N-1]}}, b} : {{(32-N){1'b0}}, b};
    p  = ia * ib;
    return p[2*N-1:0];
  endfunction

  // Handshakes are judged mid-cycle, when inputs and outputs are settled
  always @(negedge clk) begin
    logic [2*N+1:0] exp_v;
    if (!rst) begin
      if (res_vld && res_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got res=%h id=%0d sg=%0d, expected none", res, res_id, res_signed);
        end else begin
          exp_v = sb.pop_front();
          if ({res, res_id, res_signed} !== exp_v) begin
            errors++;
            $display("FAIL scoreboard: got res=%h id=%0d sg=%0d, expected res=%h id=%0d sg=%0d",
                     res, res_id, res_signed, exp_v[2*N+1:2], exp_v[1], exp_v[0]);
          end
        end
      end
      if (req0_vld && req0_rdy)
        sb.push_back({ref_mul(req0_a, req0_b, req0_signed), 1'b0, req0_signed});
      if (req1_vld && req1_rdy)
        sb.push_back({ref_mul(req1_a, req1_b, req1_signed), 1'b1, req1_signed});
      if (req0_rdy && req1_rdy) begin
        checks++;
        errors++;
        $display("FAIL dual_rdy: got req0_rdy=1 req1_rdy=1, expected at most one");
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_vld = 1'b0;
    req1_vld = 1'b0;
  endtask

  task automatic drain();
    int guard;
    idle_inputs();
    res_rdy = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      next_cycle();
      guard++;
    end
    next_cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    res_rdy = 1'b1;
    repeat (2) next_cycle();
    checks++;
    if ({res_vld, res, res_id, res_signed} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%0d res=%h id=%0d sg=%0d, expected all 0", res_vld, res, res_id, res_signed);
    end
    rst = 1'b0;
    sb.delete();
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    #1;
    checks++;
    if ({req0_rdy, req1_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_tie: got rdy0=%0d rdy1=%0d, expected rdy0=1 rdy1=0", req0_rdy, req1_rdy);
    end
    idle_inputs();
    #1;
    checks++;
    if (res_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_vld: got res_vld=%0d, expected 0", res_vld);
    end
  endtask

  task automatic test_unsigned_basic();
    next_cycle();
    req0_vld = 1'b1; req0_a = 4'hF; req0_b = 4'hF; req0_signed = 1'b0;
    #1;
    checks++;
    if (req0_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_rdy: got req0_rdy=%0d, expected 1", req0_rdy);
    end
    next_cycle();
    req0_vld = 1'b0;
    checks++;
    if (res_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got res_vld=%0d one edge after accept, expected 0", res_vld);
    end
    next_cycle();
    checks++;
    if ({res_vld, res, res_id, res_signed} !== {1'b1, 8'hE1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_latency: got vld=%0d res=%h id=%0d sg=%0d, expected vld=1 res=e1 id=0 sg=0", res_vld, res, res_id, res_signed);
    end
    drain();
  endtask

  task automatic test_signed_pair();
    next_cycle();
    req1_vld = 1'b1; req1_a = 4'h8; req1_b = 4'h8; req1_signed = 1'b1;
    next_cycle();
    req1_a = 4'hF; req1_b = 4'h7;
    next_cycle();
    req1_vld = 1'b0;
    checks++;
    if ({res_vld, res, res_id, res_signed} !== {1'b1, 8'h40, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL signed_first: got vld=%0d res=%h id=%0d sg=%0d, expected vld=1 res=40 id=1 sg=1", res_vld, res, res_id, res_signed);
    end
    next_cycle();
    checks++;
    if ({res_vld, res, res_id, res_signed} !== {1'b1, 8'hF9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL signed_second: got vld=%0d res=%h id=%0d sg=%0d, expected vld=1 res=f9 id=1 sg=1", res_vld, res, res_id, res_signed);
    end
    drain();
  endtask

  task automatic test_alternate();
    logic prev0;
    logic prev_id;
    prev0 = 1'b0;
    prev_id = 1'b0;
    res_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      req0_vld = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_signed = 1'($urandom);
      req1_vld = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_signed = 1'($urandom);
      #1;
      checks++;
      if ((req0_rdy ^ req1_rdy) !== 1'b1) begin
        errors++;
        $display("FAIL alt_one_rdy: cycle %0d got rdy0=%0d rdy1=%0d, expected exactly one", i, req0_rdy, req1_rdy);
      end
      if (i > 0) begin
        checks++;
        if (req0_rdy === prev0) begin
          errors++;
          $display("FAIL alt_toggle: cycle %0d got rdy0=%0d again, expected %0d", i, req0_rdy, !prev0);
        end
      end
      if (i > 2) begin
        checks++;
        if (res_vld !== 1'b1 || res_id === prev_id) begin
          errors++;
          $display("FAIL alt_result: cycle %0d got vld=%0d id=%0d, expected vld=1 id=%0d", i, res_vld, res_id, !prev_id);
        end
      end
      prev0 = req0_rdy;
      prev_id = res_id;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [2*N+1:0] held;
    held = '0;
    res_rdy = 1'b1;
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    repeat (4) begin
      next_cycle();
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_signed = 1'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_signed = 1'($urandom);
    end
    res_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      #1;
      if (i == 0) held = {res, res_id, res_signed};
      checks++;
      if ({res_vld, res, res_id, res_signed} !== {1'b1, held}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got vld=%0d res=%h, expected vld=1 res=%h", i, res_vld, res, held[2*N+1:2]);
      end
      checks++;
      if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_rdy: cycle %0d got rdy0=%0d rdy1=%0d, expected both 0", i, req0_rdy, req1_rdy);
      end
    end
    res_rdy = 1'b1;
    repeat (3) next_cycle();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      next_cycle();
      req0_vld = 1'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom); req0_signed = 1'($urandom);
      req1_vld = 1'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom); req1_signed = 1'($urandom);
      res_rdy = ($urandom_range(0, 9) < 7);
      if (i % 50 == 0) begin
        checks++;
        if (sb.size() > 2) begin
          errors++;
          $display("FAIL inflight: got %0d in flight, expected at most 2", sb.size());
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    res_rdy = 1'b0;
    req0_vld = 1'b1; req0_a = 4'h3; req0_b = 4'h5; req0_signed = 1'b0;
    repeat (3) next_cycle();
    idle_inputs();
    rst = 1'b1;
    sb.delete();
    next_cycle();
    rst = 1'b0;
    res_rdy = 1'b1;
    checks++;
    if (res_vld !== 1'b0 || res !== '0) begin
      errors++;
      $display("FAIL rst_flush: got vld=%0d res=%h, expected vld=0 res=00", res_vld, res);
    end
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    #1;
    checks++;
    if ({req0_rdy, req1_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL rst_tie: got rdy0=%0d rdy1=%0d, expected rdy0=1 rdy1=0", req0_rdy, req1_rdy);
    end
    idle_inputs();
    repeat (3) begin
      next_cycle();
      checks++;
      if (res_vld !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale: got res_vld=%0d, expected 0", res_vld);
      end
    end
  endtask

  task automatic test_sweep();
    int accepted;
    accepted = 0;
    res_rdy = 1'b1;
    req1_vld = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          next_cycle();
          req0_vld = 1'b1; req0_a = 4'(a); req0_b = 4'(b); req0_signed = 1'(s);
          #1;
          if (req0_rdy === 1'b1) accepted++;
        end
      end
    end
    next_cycle();
    checks++;
    if (accepted != 512) begin
      errors++;
      $display("FAIL sweep_accepts: got %0d accepted, expected 512", accepted);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_pair();
    test_alternate();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
